// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   br_div_t    : 11-bit baud-rate divisor driven into BR_gen.
//   ab_state_e  : autobaud FSM states.
//   DEF_DIV     : divisor loaded at reset (16x oversampling of 9600 baud at 100 MHz).
//   OVS_LOG2    : log2 of the receiver oversampling factor.
package uart_pkg;

    typedef logic [10:0] br_div_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FALL,
        MEASURE,
        RESULT
    } ab_state_e;

    localparam br_div_t DEF_DIV  = 11'd650;
    localparam int      OVS_LOG2 = 4;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous, idle-high line, with
// single-cycle edge pulses derived from the synchronized value.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   d    : asynchronous input
//   q    : synchronized input (two cycles of latency)
//   rise : q went 0 -> 1 this cycle
//   fall : q went 1 -> 0 this cycle
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s2_prev;

    // Flops reset to 1 so an idle-high line produces no edge on reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            s2_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the value
            // its predecessor held before this edge, forming a real shift chain.
            s1      <= d;
            s2      <= s1;
            s2_prev <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s2_prev;
    assign fall = ~s2 & s2_prev;

endmodule

// File: rtl/br_ctrl.sv
// Baud-rate configuration controller for BR_gen.
// Owns the divisor, accepts host writes over valid/ready, optionally measures
// the start bit of a 0x55 sync character (autobaud), and applies any new
// divisor only on a BR_gen tick so the generator never sees a mid-period change.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   cfg_valid : host divisor write request
//   cfg_div   : host divisor value (0 is clamped to 1)
//   cfg_ready : controller can accept a host write
//   ab_start  : single-cycle pulse arming autobaud
//   rx        : asynchronous serial line, idle high
//   tick      : pulse from BR_gen
//   br_div    : divisor to BR_gen
//   locked    : br_div equals the latest accepted/measured value
//   ab_busy   : autobaud in progress
//   ab_done   : one-cycle pulse, autobaud succeeded
//   ab_err    : one-cycle pulse, autobaud failed (timeout or glitch)
module br_ctrl #(
    parameter logic [10:0] DEF_DIV  = uart_pkg::DEF_DIV,
    parameter int          OVS_LOG2 = uart_pkg::OVS_LOG2,
    parameter int          CNT_W    = 15,
    parameter int          MIN_Q    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    input  logic [10:0] cfg_div,
    output logic        cfg_ready,
    input  logic        ab_start,
    input  logic        rx,
    input  logic        tick,
    output logic [10:0] br_div,
    output logic        locked,
    output logic        ab_busy,
    output logic        ab_done,
    output logic        ab_err
);

    import uart_pkg::*;

    localparam int               QW      = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [QW-1:0]    HALF    = QW'(1 << (OVS_LOG2 - 1));

    ab_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             done_nxt, err_nxt;

    br_div_t          pend_div;
    logic             pend_flag;

    logic             rx_s, rx_rise, rx_fall;
    logic [QW-1:0]    q_full;
    logic             q_ok;
    logic             host_wr;

    sync_edge u_rx_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (rx),
        .q    (rx_s),
        .rise (rx_rise),
        .fall (rx_fall)
    );

    // Start-bit length divided by the oversampling factor, rounded to nearest.
    assign q_full = ({1'b0, cnt} + HALF) >> OVS_LOG2;
    assign q_ok   = (q_full >= QW'(MIN_Q)) && (q_full <= QW'(2048));

    assign cfg_ready = (state == IDLE) && !pend_flag;
    assign host_wr   = cfg_valid && cfg_ready;
    assign ab_busy   = (state != IDLE);
    assign locked    = !pend_flag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ab_done <= 1'b0;
            ab_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ab_done <= done_nxt;
            ab_err  <= err_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ab_start) state_nxt = WAIT_FALL;
            end
            WAIT_FALL: begin
                if (rx_fall) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                // A rising edge wins over saturation: a complete start bit is measured.
                if (rx_rise) begin
                    state_nxt = RESULT;
                end else if (cnt == CNT_MAX) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (!rx_s) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RESULT: begin
                done_nxt  = q_ok;
                err_nxt   = !q_ok;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pending/apply path. Host writes and autobaud results are mutually
    // exclusive (IDLE vs RESULT), so a single else-if suffices.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_div    <= DEF_DIV;
            pend_div  <= DEF_DIV;
            pend_flag <= 1'b0;
        end else begin
            if (tick && pend_flag) begin
                br_div    <= pend_div;
                pend_flag <= 1'b0;
            end
            // NOTE: a later non-blocking assignment to the same flop wins, so a
            // new value arriving on a tick stays pending for the next tick.
            if (host_wr) begin
                pend_div  <= (cfg_div == 11'd0) ? 11'd1 : cfg_div;
                pend_flag <= 1'b1;
            end else if (state == RESULT && q_ok) begin
                pend_div  <= 11'(q_full - QW'(1));
                pend_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_br_ctrl.sv
// Self-checking bench for br_ctrl. A free-running BR_gen model supplies tick;
// autobaud expectations come from a rounding-division model of the start bit.
module tb_br_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [10:0] cfg_div;
    logic        cfg_ready;
    logic        ab_start;
    logic        rx;
    logic        tick;
    logic [10:0] br_div;
    logic        locked;
    logic        ab_busy;
    logic        ab_done;
    logic        ab_err;

    int n_checks = 0;
    int n_errs   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [10:0] exp_div;

    br_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .ab_start  (ab_start),
        .rx        (rx),
        .tick      (tick),
        .br_div    (br_div),
        .locked    (locked),
        .ab_busy   (ab_busy),
        .ab_done   (ab_done),
        .ab_err    (ab_err)
    );

    always #5 clk = ~clk;

    // BR_gen: one tick every br_div+1 clocks, free running.
    logic [10:0] bg_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst)                 bg_cnt <= '0;
        else if (bg_cnt >= br_div) bg_cnt <= '0;
        else                      bg_cnt <= bg_cnt + 11'd1;
    end
    assign tick = rst && (bg_cnt >= br_div);

    always @(negedge clk) begin
        if (ab_done) done_cnt++;
        if (ab_err)  err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for a tick, then steps past the edge that consumes it.
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 4200; i++) begin
            if (tick) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("tick_seen", 32'(seen), 32'd1);
        step();
    endtask

    task automatic host_write(input logic [10:0] v);
        bit taken = 1'b0;
        cfg_valid = 1'b1;
        cfg_div   = v;
        for (int i = 0; i < 4200; i++) begin
            if (cfg_ready) begin
                taken = 1'b1;
                step();
                break;
            end
            step();
        end
        cfg_valid = 1'b0;
        check("host_write_taken", 32'(taken), 32'd1);
    endtask

    // Reference: start bit of n clocks -> quotient n/16 rounded to nearest.
    function automatic void ab_model(input int n, output bit ok, output logic [10:0] div);
        int q;
        if (n >= 32767) begin
            ok  = 1'b0;
            div = '0;
            return;
        end
        q   = (n + 8) / 16;
        ok  = (q >= 2) && (q <= 2048);
        div = 11'(q - 1);
    endfunction

    task automatic run_ab(input string tag, input int n_low);
        bit          ok;
        logic [10:0] ediv;
        int          d0, e0;
        ab_model(n_low, ok, ediv);
        d0 = done_cnt;
        e0 = err_cnt;
        ab_start = 1'b1;
        step();
        ab_start = 1'b0;
        check({tag, "_busy"}, 32'(ab_busy), 32'd1);
        repeat (3) step();
        rx = 1'b0;
        repeat (n_low) step();
        rx = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done_cnt != d0 || err_cnt != e0) break;
            step();
        end
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'(ok));
        check({tag, "_err_pulses"},  32'(err_cnt - e0),  32'(!ok));
        check({tag, "_busy_clr"},    32'(ab_busy), 32'd0);
        if (ok) begin
            wait_tick();
            exp_div = ediv;
            check({tag, "_br_div"}, 32'(br_div), 32'(exp_div));
            check({tag, "_locked"}, 32'(locked), 32'd1);
        end else begin
            check({tag, "_br_div_kept"}, 32'(br_div), 32'(exp_div));
            check({tag, "_cfg_ready"},   32'(cfg_ready), 32'd1);
        end
    endtask

    initial begin
        int n;
        int d0, e0;
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        ab_start  = 1'b0;
        rx        = 1'b1;
        exp_div   = 11'd650;

        repeat (3) step();
        check("rst_br_div", 32'(br_div), 32'd650);
        rst = 1'b1;
        step();
        check("rel_br_div",    32'(br_div),    32'd650);
        check("rel_locked",    32'(locked),    32'd1);
        check("rel_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rel_ab_busy",   32'(ab_busy),   32'd0);
        repeat (1000) step();
        check("idle_no_pulses", 32'(done_cnt + err_cnt), 32'd0);

        // Host write mid-period, then apply at the tick.
        repeat (123) step();
        host_write(11'd325);
        check("wr_cfg_ready_low", 32'(cfg_ready), 32'd0);
        check("wr_locked_low",    32'(locked),    32'd0);
        check("wr_br_div_old",    32'(br_div),    32'd650);
        wait_tick();
        exp_div = 11'd325;
        check("wr_br_div_new", 32'(br_div), 32'(exp_div));
        check("wr_locked",     32'(locked), 32'd1);
        n = 0;
        while (!tick && n < 4200) begin
            step();
            n++;
        end
        check("tick_spacing", 32'(n + 1), 32'd326);

        // Back-to-back writes: second is held off until the first applies.
        host_write(11'd100);
        host_write(11'd200);
        wait_tick();
        exp_div = 11'd200;
        check("holdoff_br_div", 32'(br_div), 32'(exp_div));

        // Zero clamps to 1.
        host_write(11'd0);
        wait_tick();
        exp_div = 11'd1;
        check("clamp_br_div", 32'(br_div), 32'(exp_div));
        host_write(11'd650);
        wait_tick();
        exp_div = 11'd650;

        // Autobaud: directed 9600/19200, random lengths, glitch, timeout.
        run_ab("ab_9600", 10416);
        run_ab("ab_19200", 5208);
        for (int i = 0; i < 4; i++) begin
            run_ab("ab_rand", int'($urandom_range(16, 2000)));
        end
        run_ab("ab_glitch", 20);
        run_ab("ab_timeout", 40000);

        // Reset in the middle of a measurement.
        host_write(11'd100);
        wait_tick();
        exp_div = 11'd100;
        check("pre_rst_br_div", 32'(br_div), 32'(exp_div));
        ab_start = 1'b1;
        step();
        ab_start = 1'b0;
        rx = 1'b0;
        repeat (50) step();
        #2 rst = 1'b0;
        #1;
        check("async_rst_br_div", 32'(br_div),  32'd650);
        check("async_rst_busy",   32'(ab_busy), 32'd0);
        step();
        step();
        rst = 1'b1;
        d0 = done_cnt;
        e0 = err_cnt;
        repeat (5) begin
            repeat (4) step();
            rx = 1'b1;
            repeat (4) step();
            rx = 1'b0;
        end
        rx = 1'b1;
        repeat (5) step();
        check("post_rst_busy",    32'(ab_busy), 32'd0);
        check("post_rst_pulses",  32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        check("post_rst_br_div",  32'(br_div),  32'd650);
        check("post_rst_ready",   32'(cfg_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
